// File: rtl/shade_ramp_ctrl_if.sv
// Control/status bundle between the home controller side and shade_ramp_ctrl.
// master drives time code, light settings and overrides; slave reports positions.
interface shade_ramp_ctrl_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned LVL_W = 4
);
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [3:0]            tcode;
   logic [N_CH*LVL_W-1:0] ulight;
   logic                  ovr_valid;
   logic [CH_W-1:0]       ovr_ch;
   logic [LVL_W-1:0]      ovr_level;
   logic [N_CH*LVL_W-1:0] wshade;
   logic [N_CH-1:0]       moving;
   logic [N_CH-1:0]       done;

   modport master (
      output tcode, ulight, ovr_valid, ovr_ch, ovr_level,
      input  wshade, moving, done
   );

   modport slave (
      input  tcode, ulight, ovr_valid, ovr_ch, ovr_level,
      output wshade, moving, done
   );
endinterface

// File: rtl/shade_ramp_ctrl.sv
// Multi-channel shade controller: picks a per-channel target (time code, user level or
// override) and slews each motor position toward it by one level per shared step tick.
module shade_ramp_ctrl #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned LVL_W    = 4,
   parameter int unsigned STEP_DIV = 4
) (
   input logic              clk,
   input logic              rst,
   shade_ramp_ctrl_if.slave bus
);
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [LVL_W-1:0] LvlMax = {LVL_W{1'b1}};
   // Top two bits set, rest clear.
   localparam logic [LVL_W-1:0] LvlHi  = ~(LvlMax >> 2);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

   logic [3:0]                  tcode_q;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [N_CH-1:0]             ovr_active_q, ovr_active_d;
   logic [N_CH-1:0][LVL_W-1:0]  ovr_level_q, ovr_level_d;
   logic [N_CH-1:0][LVL_W-1:0]  pos_q, pos_d;
   logic [N_CH-1:0]             moving_q, moving_d;
   logic [N_CH-1:0]             done_q, done_d;
   logic [N_CH-1:0][LVL_W-1:0]  target;
   state_e                      state [N_CH];
   logic                        tick;
   logic                        tcode_chg;
   logic                        ovr_hit;

   assign tick      = (cnt_q == CntLast);
   assign cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
   assign tcode_chg = (bus.tcode != tcode_q);
   assign ovr_hit   = bus.ovr_valid && ({{(32-CH_W){1'b0}}, bus.ovr_ch} < N_CH);

   always_comb begin
      target = '0;
      for (int i = 0; i < N_CH; i++) begin
         state[i] = StIdle;
         if (ovr_active_q[i]) begin
            target[i] = ovr_level_q[i];
         end else begin
            case (bus.tcode)
               4'b0001: target[i] = LvlMax;
               4'b0010: target[i] = LvlHi;
               4'b0100: target[i] = bus.ulight[i*LVL_W +: LVL_W];
               default: target[i] = '0;
            endcase
         end
         if (pos_q[i] < target[i]) begin
            state[i] = StUp;
         end else if (pos_q[i] > target[i]) begin
            state[i] = StDown;
         end
      end
   end

   always_comb begin
      // A time-code change drops all overrides; a same-cycle override is applied afterwards.
      ovr_active_d = tcode_chg ? '0 : ovr_active_q;
      ovr_level_d  = ovr_level_q;
      if (ovr_hit) begin
         for (int i = 0; i < N_CH; i++) begin
            if (bus.ovr_ch == CH_W'(i)) begin
               ovr_active_d[i] = 1'b1;
               ovr_level_d[i]  = bus.ovr_level;
            end
         end
      end
   end

   always_comb begin
      pos_d    = pos_q;
      moving_d = '0;
      done_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
         moving_d[i] = (state[i] != StIdle);
         unique case (state[i])
            StIdle: pos_d[i] = pos_q[i];
            StUp: begin
               if (tick && pos_q[i] != LvlMax) pos_d[i] = pos_q[i] + LVL_W'(1);
            end
            StDown: begin
               if (tick && pos_q[i] != '0) pos_d[i] = pos_q[i] - LVL_W'(1);
            end
            default: pos_d[i] = pos_q[i];
         endcase
         // Only a tick-step landing on target reports done, never a target jump onto pos.
         done_d[i] = tick && (state[i] != StIdle) && (pos_d[i] == target[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcode_q      <= '0;
         cnt_q        <= '0;
         ovr_active_q <= '0;
         ovr_level_q  <= '0;
         pos_q        <= '0;
         moving_q     <= '0;
         done_q       <= '0;
      end else begin
         tcode_q      <= bus.tcode;
         cnt_q        <= cnt_d;
         ovr_active_q <= ovr_active_d;
         ovr_level_q  <= ovr_level_d;
         pos_q        <= pos_d;
         moving_q     <= moving_d;
         done_q       <= done_d;
      end
   end

   assign bus.wshade = pos_q;
   assign bus.moving = moving_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_shade_ramp_ctrl.sv
// Directed bench for shade_ramp_ctrl; three channels so that ovr_ch=3 is encodable
// yet out of range. Edges are counted from each reset release.
module tb_shade_ramp_ctrl;
   localparam int unsigned N_CH     = 3;
   localparam int unsigned LVL_W    = 4;
   localparam int unsigned STEP_DIV = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   int   e = 0;
   int   dcnt [N_CH];

   shade_ramp_ctrl_if #(.N_CH(N_CH), .LVL_W(LVL_W)) bus ();

   shade_ramp_ctrl #(
      .N_CH    (N_CH),
      .LVL_W   (LVL_W),
      .STEP_DIV(STEP_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N_CH; i++) begin
         if (rst) dcnt[i] = 0;
         else if (bus.done[i]) dcnt[i] = dcnt[i] + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic to_edge(input int target);
      while (e < target) begin
         @(negedge clk);
         e++;
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.tcode     = 4'b0001;
      bus.ulight    = '0;
      bus.ovr_valid = 1'b0;
      bus.ovr_ch    = '0;
      bus.ovr_level = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_wshade", 32'(bus.wshade), 32'h000);
      check_eq("rst_moving", 32'(bus.moving), 32'h0);
      check_eq("rst_done",   32'(bus.done),   32'h0);
      rst = 1'b0;
      e   = 0;

      // Ramp up to all ones.
      to_edge(1);  check_eq("s1_moving_e1", 32'(bus.moving), 32'h7);
      to_edge(3);  check_eq("s1_pos_e3",    32'(bus.wshade), 32'h000);
      to_edge(4);  check_eq("s1_pos_e4",    32'(bus.wshade), 32'h111);
      to_edge(8);  check_eq("s1_pos_e8",    32'(bus.wshade), 32'h222);
      to_edge(59);
      check_eq("s1_pos_e59",  32'(bus.wshade), 32'hEEE);
      check_eq("s1_done_e59", 32'(bus.done),   32'h0);
      to_edge(60);
      check_eq("s1_pos_e60",    32'(bus.wshade), 32'hFFF);
      check_eq("s1_done_e60",   32'(bus.done),   32'h7);
      check_eq("s1_moving_e60", 32'(bus.moving), 32'h7);
      to_edge(61);
      check_eq("s1_done_e61",   32'(bus.done),   32'h0);
      check_eq("s1_moving_e61", 32'(bus.moving), 32'h0);
      check_eq("s1_dcnt0", 32'(dcnt[0]), 32'd1);
      check_eq("s1_dcnt1", 32'(dcnt[1]), 32'd1);

      // Down to 12.
      bus.tcode = 4'b0010;
      to_edge(63); check_eq("s2_pos_e63", 32'(bus.wshade), 32'hFFF);
      to_edge(64); check_eq("s2_pos_e64", 32'(bus.wshade), 32'hEEE);
      to_edge(72);
      check_eq("s2_pos_e72",  32'(bus.wshade), 32'hCCC);
      check_eq("s2_done_e72", 32'(bus.done),   32'h7);
      to_edge(73); check_eq("s2_moving_e73", 32'(bus.moving), 32'h0);

      // User levels: ch0=5, ch1=9, ch2=12.
      bus.ulight = 12'hC95;
      bus.tcode  = 4'b0100;
      to_edge(84);
      check_eq("s3_pos_e84",  32'(bus.wshade), 32'hC99);
      check_eq("s3_done_e84", 32'(bus.done),   32'h2);
      to_edge(85); check_eq("s3_done_e85", 32'(bus.done), 32'h0);
      to_edge(100);
      check_eq("s3_pos_e100",  32'(bus.wshade), 32'hC95);
      check_eq("s3_done_e100", 32'(bus.done),   32'h1);
      to_edge(101); check_eq("s3_moving_e101", 32'(bus.moving), 32'h0);

      // Override ch1 to 2, then time-code change clears it.
      bus.ovr_valid = 1'b1;
      bus.ovr_ch    = 2'd1;
      bus.ovr_level = 4'd2;
      to_edge(102);
      bus.ovr_valid = 1'b0;
      check_eq("s4_moving_e102", 32'(bus.moving), 32'h0);
      to_edge(103); check_eq("s4_moving_e103", 32'(bus.moving), 32'h2);
      to_edge(104); check_eq("s4_pos_e104",    32'(bus.wshade), 32'hC85);
      to_edge(128);
      check_eq("s4_pos_e128",  32'(bus.wshade), 32'hC25);
      check_eq("s4_done_e128", 32'(bus.done),   32'h2);
      bus.tcode = 4'b1000;
      to_edge(132); check_eq("s4_pos_e132", 32'(bus.wshade), 32'hB14);
      to_edge(136);
      check_eq("s4_pos_e136",  32'(bus.wshade), 32'hA03);
      check_eq("s4_done_e136", 32'(bus.done),   32'h2);
      to_edge(148);
      check_eq("s4_pos_e148",  32'(bus.wshade), 32'h700);
      check_eq("s4_done_e148", 32'(bus.done),   32'h1);
      to_edge(176);
      check_eq("s4_pos_e176",  32'(bus.wshade), 32'h000);
      check_eq("s4_done_e176", 32'(bus.done),   32'h4);

      // Override together with a time-code change: override wins.
      bus.tcode     = 4'b0001;
      bus.ovr_valid = 1'b1;
      bus.ovr_ch    = 2'd1;
      bus.ovr_level = 4'd7;
      to_edge(177);
      bus.ovr_valid = 1'b0;
      to_edge(204);
      check_eq("s5_pos_e204",  32'(bus.wshade), 32'h777);
      check_eq("s5_done_e204", 32'(bus.done),   32'h2);
      to_edge(208);
      check_eq("s5_pos_e208",  32'(bus.wshade), 32'h878);
      // Out-of-range channel is ignored.
      bus.ovr_valid = 1'b1;
      bus.ovr_ch    = 2'd3;
      bus.ovr_level = 4'd1;
      to_edge(209);
      bus.ovr_valid = 1'b0;
      to_edge(212); check_eq("s5_pos_e212", 32'(bus.wshade), 32'h979);
      to_edge(236);
      check_eq("s5_pos_e236",  32'(bus.wshade), 32'hF7F);
      check_eq("s5_done_e236", 32'(bus.done),   32'h5);

      // Reset, then reversal mid-ramp.
      rst        = 1'b1;
      bus.tcode  = 4'b0100;
      bus.ulight = 12'h00F;
      @(negedge clk);
      check_eq("s6_rst_wshade", 32'(bus.wshade), 32'h000);
      rst = 1'b0;
      e   = 0;
      to_edge(24);
      check_eq("s6_pos_r24", 32'(bus.wshade), 32'h006);
      bus.ulight = 12'h003;
      to_edge(25); check_eq("s6_done_r25", 32'(bus.done),   32'h0);
      to_edge(28); check_eq("s6_pos_r28",  32'(bus.wshade), 32'h005);
      to_edge(32); check_eq("s6_pos_r32",  32'(bus.wshade), 32'h004);
      to_edge(36);
      check_eq("s6_pos_r36",  32'(bus.wshade), 32'h003);
      check_eq("s6_done_r36", 32'(bus.done),   32'h1);
      check_eq("s6_dcnt0",    32'(dcnt[0]),    32'd1);

      // Reset while moving.
      bus.ulight = 12'h00F;
      to_edge(44);
      check_eq("s6_pos_r44",    32'(bus.wshade), 32'h005);
      to_edge(45);
      check_eq("s6_moving_r45", 32'(bus.moving), 32'h1);
      rst = 1'b1;
      to_edge(46);
      check_eq("s6_mid_wshade", 32'(bus.wshade), 32'h000);
      check_eq("s6_mid_moving", 32'(bus.moving), 32'h0);
      check_eq("s6_mid_done",   32'(bus.done),   32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/shade_ramp_ctrl.md
Name: shade_ramp_ctrl

Overview:
Multi-channel window-shade controller. Per channel, it derives a target shade level from the time code, the per-channel user light setting, or a manual override. It then slews the motor position toward that target one level per step tick, instead of jumping. It sits between the time-code decoder and the shade motor drivers, and reports moving/done status to the home controller.

Parameters:
N_CH, 4, number of independent shade channels
LVL_W, 4, width of one shade level (minimum 2)
STEP_DIV, 4, clock cycles per position step (minimum 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
tcode  in  4  time code: 0001 / 0010 / 0100 / other
ulight  in  N_CH*LVL_W  per-channel user light level; channel i at bits [i*LVL_W +: LVL_W]
ovr_valid  in  1  manual override strobe, sampled each cycle
ovr_ch  in  $clog2(N_CH) (min 1)  channel to override
ovr_level  in  LVL_W  override level
wshade  out  N_CH*LVL_W  current shade position per channel (registered)
moving  out  N_CH  channel position is not equal to its target (registered)
done  out  N_CH  one-cycle pulse when a step lands the channel on its target

Behaviour:
- Only clk and rst are used for sequencing; reset is synchronous and active-high.
- Reset values:
  - wshade = 0, moving = 0, done = 0
  - all override-active flags = 0
  - step counter = 0
  - tcode_q = 0000
- Reset takes priority over all inputs in the same cycle.
- Reset mid-move: positions return to 0 on the next edge, with no done pulse.
- Base target per channel, combinational, using the current tcode:
  - 0001 → all ones
  - 0010 → {2'b11, zeros}, i.e. 12 for LVL_W=4
  - 0100 → that channel's ulight slice
  - any other code → 0
- Override:
  - When ovr_valid=1 and ovr_ch<N_CH, set ovr_active[ovr_ch]=1 and latch ovr_level for that channel.
  - When ovr_ch>=N_CH, ignore the request entirely.
  - While ovr_active, the channel target = latched override level.
- tcode change:
  - tcode_q registers tcode every cycle.
  - When tcode != tcode_q, clear all ovr_active flags.
  - If an override arrives in the same cycle as a tcode change, the override wins for its channel (it is applied after the clear).
- Step tick:
  - Counter runs 0..STEP_DIV-1 continuously and wraps.
  - tick=1 in the cycle the counter = STEP_DIV-1.
  - With STEP_DIV=1, tick=1 every cycle.
- Per-channel state machine, evaluated every cycle against the current target:
  - IDLE (pos==target)
  - UP (pos<target)
  - DOWN (pos>target)
- Moving the position:
  - On tick, pos changes by +1 in UP or -1 in DOWN, and is unchanged in IDLE.
  - Position never overshoots the target and never wraps; it saturates at 0 and all-ones.
- Target change mid-move:
  - The state re-evaluates in the same cycle, so direction reverses on the next tick.
  - If the new target equals pos, the channel goes IDLE with no done pulse.
- moving[i] = registered (state != IDLE), giving 1-cycle latency from the state change.
- done[i] is high for exactly one cycle, in the cycle after a tick-step makes pos equal to target.
- Channels are fully independent and share only the tick.

Test Plan:
Unless stated otherwise, all scenarios use N_CH=2, LVL_W=4, STEP_DIV=4.

1. Release rst with tcode=0001 → both wshade slices step 0→15, one step every 4 cycles; first step at the 4th edge after release; 15 at edge 60. Each done pulses once; moving drops 1 cycle after the final step.
2. From settled 15, change tcode to 0010 → both ramp 15→14→13→12 over 3 ticks, then done pulses.
3. tcode=0100, ulight ch0=5, ch1=9, starting from 12 → ch0 reaches 5 after 7 ticks, ch1 reaches 9 after 3 ticks. ch1 done fires 4 ticks before ch0 done.
4. Override: ovr_valid, ovr_ch=1, ovr_level=2 → ch1 ramps to 2 while ch0 is unaffected. Then change tcode to 1000 → override is cleared and ch1 ramps to 0.
5. Overrides in the same cycle as a tcode change:
   - ovr_ch=1, ovr_level=7 together with a tcode change → ch1 still targets 7.
   - ovr_ch=3 (out of range) → no state change on either channel.
6. Reversal and reset mid-move:
   - ch0 ramping 0→15, reaches 6, target switched to 3 (ulight) → next ticks give 5, 4, 3; no done pulse at 6.
   - Assert rst while ch0 is moving → wshade=0, moving=0, done=0 on the next edge.
